data_cache_controller: RTL and testbench

- Responder end of the CPU data-memory interface. Receives load/store requests from pipeline stage 4: read-enable, write-enable, address and store data.
- Returns load data and a busy-wait stall signal.
- Direct-mapped, write-back, write-allocate cache with 16-byte lines.
- Backed by a block-wide main-memory port that has its own busy-wait handshake.

---
 rtl/data_cache_controller_if.sv | 26 ++
 rtl/data_cache_controller.sv | 138 +++++++++++++
 tb/tb_data_cache_controller.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_controller_if.sv
// CPU-side load/store port and block-wide main-memory port of the data cache.
// master = CPU/memory environment view, slave = the cache controller.
interface data_cache_controller_if;
    logic [3:0]   READ_EN;
    logic [2:0]   WRITE_EN;
    logic [31:0]  ADDR;
    logic [31:0]  WRITE_DATA;
    logic [31:0]  READ_DATA;
    logic         BUSY_WAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDR;
    logic [127:0] MEM_WRITE_DATA;
    logic [127:0] MEM_READ_DATA;
    logic         MEM_BUSY_WAIT;

    modport master (
        output READ_EN, WRITE_EN, ADDR, WRITE_DATA, MEM_READ_DATA, MEM_BUSY_WAIT,
        input  READ_DATA, BUSY_WAIT, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA
    );

    modport slave (
        input  READ_EN, WRITE_EN, ADDR, WRITE_DATA, MEM_READ_DATA, MEM_BUSY_WAIT,
        output READ_DATA, BUSY_WAIT, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA
    );
endinterface

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Hits (loads and stores) are zero-stall; misses run WRITEBACK/FETCH/INSTALL.
module data_cache_controller #(
    parameter int NUM_LINES = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    data_cache_controller_if.slave  bus
);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, INSTALL} state_t;

    state_t state, state_nx;

    logic [NUM_LINES-1:0] valid, dirty;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [127:0]         data_arr [NUM_LINES];

    logic [IDX-1:0]   idx, l_idx;
    logic [TAG_W-1:0] tag, l_tag;
    logic [1:0]       word;
    logic [127:0]     fill_buf, line, merged_line;
    logic [31:0]      cur_word, st_word, ld_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic             req, hit, store_hit;
    logic             mem_read, mem_write, busy;
    logic [27:0]      mem_addr;
    logic [127:0]     mem_wdata;

    assign idx       = bus.ADDR[3+IDX:4];
    assign tag       = bus.ADDR[31:4+IDX];
    assign word      = bus.ADDR[3:2];
    assign line      = data_arr[idx];
    assign cur_word  = line[{word, 5'd0} +: 32];
    assign req       = bus.READ_EN[3] | bus.WRITE_EN[2];
    assign hit       = valid[idx] && (tag_arr[idx] == tag);
    assign store_hit = (state == IDLE) && bus.WRITE_EN[2] && hit;

    // Load path: halfword/byte lanes picked by the low address bits; ADDR[0] is ignored for halves.
    always_comb begin
        ld_byte = cur_word[{bus.ADDR[1:0], 3'd0} +: 8];
        ld_half = cur_word[{bus.ADDR[1], 4'd0} +: 16];
        case (bus.READ_EN[2:0])
            3'b000:  ld_word = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_word = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_word = {24'd0, ld_byte};
            3'b101:  ld_word = {16'd0, ld_half};
            default: ld_word = cur_word;
        endcase
    end

    always_comb begin
        st_word = cur_word;
        case (bus.WRITE_EN[1:0])
            2'b00:   st_word[{bus.ADDR[1:0], 3'd0} +: 8] = bus.WRITE_DATA[7:0];
            2'b01:   st_word[{bus.ADDR[1], 4'd0} +: 16]  = bus.WRITE_DATA[15:0];
            default: st_word = bus.WRITE_DATA;
        endcase
        merged_line = line;
        merged_line[{word, 5'd0} +: 32] = st_word;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    busy     = 1'b1;
                    state_nx = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = {tag_arr[l_idx], l_idx};
                mem_wdata = data_arr[l_idx];
                if (!bus.MEM_BUSY_WAIT) state_nx = FETCH;
            end
            FETCH: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = {l_tag, l_idx};
                if (!bus.MEM_BUSY_WAIT) state_nx = INSTALL;
            end
            INSTALL: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_nx;
            if (state == INSTALL) begin
                valid[l_idx] <= 1'b1;
                dirty[l_idx] <= 1'b0;
            end
            if (store_hit) dirty[idx] <= 1'b1;
        end
    end

    // Arrays and miss bookkeeping are not reset; index/tag are frozen at the IDLE exit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (state == IDLE && req && !hit) begin
                l_idx <= idx;
                l_tag <= tag;
            end
            if (state == FETCH && !bus.MEM_BUSY_WAIT) fill_buf <= bus.MEM_READ_DATA;
            if (state == INSTALL) begin
                data_arr[l_idx] <= fill_buf;
                tag_arr[l_idx]  <= l_tag;
            end
            if (store_hit) data_arr[idx] <= merged_line;
        end
    end

    assign bus.READ_DATA      = RESET ? ld_word : 32'd0;
    assign bus.BUSY_WAIT      = RESET & busy;
    assign bus.MEM_READ       = mem_read;
    assign bus.MEM_WRITE      = mem_write;
    assign bus.MEM_ADDR       = mem_addr;
    assign bus.MEM_WRITE_DATA = mem_wdata;
endmodule

// File: tb/tb_data_cache_controller.sv
// Randomized bench for data_cache_controller against a flat coherent-memory model
// plus per-index valid/dirty/tag bookkeeping, with a wait-state main-memory responder.
module tb_data_cache_controller;
    localparam int NL  = 8;
    localparam int IDX = $clog2(NL);

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    data_cache_controller_if bus ();
    data_cache_controller #(.NUM_LINES(NL)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] mem [logic [27:0]];
    logic [127:0] coh [logic [27:0]];
    bit           m_valid [NL];
    bit           m_dirty [NL];
    int unsigned  m_tag   [NL];
    int           mem_wait = 0;
    int           mem_cnt  = 0;

    // Memory: busy for mem_wait cycles per operation, completes on the first edge with busy low.
    always @(negedge CLK) begin
        bus.MEM_BUSY_WAIT = (bus.MEM_READ === 1'b1 || bus.MEM_WRITE === 1'b1) && (mem_cnt < mem_wait);
        bus.MEM_READ_DATA = mem.exists(bus.MEM_ADDR) ? mem[bus.MEM_ADDR] : '0;
    end

    always @(posedge CLK) begin
        if (bus.MEM_READ === 1'b1 || bus.MEM_WRITE === 1'b1) begin
            if (bus.MEM_BUSY_WAIT === 1'b1) mem_cnt <= mem_cnt + 1;
            else begin
                if (bus.MEM_WRITE === 1'b1) mem[bus.MEM_ADDR] = bus.MEM_WRITE_DATA;
                mem_cnt <= 0;
            end
        end else mem_cnt <= 0;
    end

    task automatic touch(input logic [27:0] blk);
        logic [127:0] v;
        if (!mem.exists(blk)) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            mem[blk] = v;
            coh[blk] = v;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        coh = mem;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
        logic [127:0] ln = coh[a[31:4]];
        logic [31:0]  w  = 32'(ln >> (32 * int'(a[3:2])));
        logic [7:0]   b  = 8'(w >> (8 * int'(a[1:0])));
        logic [15:0]  h  = 16'(w >> (16 * int'(a[1])));
        case (f)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [127:0] ln = coh[a[31:4]];
        int base = 32 * int'(a[3:2]);
        case (sz)
            2'd0:    ln[base + 8 * int'(a[1:0]) +: 8] = wd[7:0];
            2'd1:    ln[base + 16 * int'(a[1]) +: 16] = wd[15:0];
            default: ln[base +: 32] = wd;
        endcase
        coh[a[31:4]] = ln;
    endtask

    task automatic idle_inputs();
        bus.READ_EN    = '0;
        bus.WRITE_EN   = '0;
        bus.ADDR       = '0;
        bus.WRITE_DATA = '0;
    endtask

    // One CPU request held until BUSY_WAIT drops; busy_obs counts every cycle with BUSY_WAIT high,
    // including the cycle the request first appears.
    task automatic access(input logic [3:0] re, input logic [2:0] we, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd_obs, output int busy_obs);
        int           idx = int'(a[3+IDX:4]);
        int unsigned  tag = a >> (4 + IDX);
        logic [27:0]  blk = a[31:4];
        logic [27:0]  ev_blk, wb_addr, rd_addr;
        logic [127:0] wb_data;
        logic [31:0]  exp_rd;
        bit           hit, evd, wb_seen = 0, rd_seen = 0, both = 0;
        int           exp_busy;
        touch(blk);
        hit      = m_valid[idx] && m_tag[idx] == tag;
        evd      = !hit && m_valid[idx] && m_dirty[idx];
        ev_blk   = 28'((m_tag[idx] << IDX) | idx);
        exp_busy = hit ? 0 : 1 + (evd ? mem_wait + 1 : 0) + mem_wait + 1 + 1;
        exp_rd   = ref_load(a, re[2:0]);
        wb_addr  = '0; rd_addr = '0; wb_data = '0;
        @(negedge CLK);
        bus.READ_EN = re; bus.WRITE_EN = we; bus.ADDR = a; bus.WRITE_DATA = wd;
        #1;
        busy_obs = 0;
        while (bus.BUSY_WAIT !== 1'b0 && busy_obs < 200) begin
            busy_obs++;
            if (bus.MEM_WRITE === 1'b1 && bus.MEM_READ === 1'b1) both = 1;
            if (bus.MEM_WRITE === 1'b1 && !wb_seen) begin
                wb_seen = 1; wb_addr = bus.MEM_ADDR; wb_data = bus.MEM_WRITE_DATA;
            end
            if (bus.MEM_READ === 1'b1 && !rd_seen) begin
                rd_seen = 1; rd_addr = bus.MEM_ADDR;
            end
            @(negedge CLK); #1;
        end
        rd_obs = bus.READ_DATA;
        n_checks++;
        if (busy_obs !== exp_busy) $display("FAIL busy_cycles a=%h got %0d want %0d", a, busy_obs, exp_busy);
        else n_pass++;
        if (re[3]) begin
            n_checks++;
            if (rd_obs !== exp_rd) $display("FAIL read_data a=%h f=%0d got %h want %h", a, re[2:0], rd_obs, exp_rd);
            else n_pass++;
        end
        if (!hit) begin
            n_checks++;
            if (!rd_seen || rd_addr !== blk || both)
                $display("FAIL fetch a=%h seen=%0d addr got %h want %h overlap=%0d", a, rd_seen, rd_addr, blk, both);
            else n_pass++;
            n_checks++;
            if (wb_seen != evd) $display("FAIL writeback_presence a=%h got %0d want %0d", a, wb_seen, evd);
            else n_pass++;
        end
        if (evd) begin
            n_checks++;
            if (wb_addr !== ev_blk || wb_data !== coh[ev_blk])
                $display("FAIL writeback a=%h got %h/%h want %h/%h", a, wb_addr, wb_data, ev_blk, coh[ev_blk]);
            else n_pass++;
        end
        if (!hit) begin
            m_valid[idx] = 1; m_tag[idx] = tag; m_dirty[idx] = 0;
        end
        if (we[2]) begin
            ref_store(a, we[1:0], wd);
            m_dirty[idx] = 1;
        end
        @(posedge CLK); #1;
        idle_inputs();
    endtask

    logic [31:0] rd;
    int          b;

    task automatic test_reset();
        RESET = 1'b0;
        bus.READ_EN = 4'b1010; bus.WRITE_EN = '0; bus.ADDR = 32'h40; bus.WRITE_DATA = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        n_checks++;
        if (bus.READ_DATA !== 32'd0 || bus.BUSY_WAIT !== 1'b0)
            $display("FAIL reset_cpu_outputs got rd=%h bw=%b want 0/0", bus.READ_DATA, bus.BUSY_WAIT);
        else n_pass++;
        n_checks++;
        if (bus.MEM_READ !== 1'b0 || bus.MEM_WRITE !== 1'b0)
            $display("FAIL reset_mem_ctrl got r=%b w=%b want 0/0", bus.MEM_READ, bus.MEM_WRITE);
        else n_pass++;
        RESET = 1'b1;
        idle_inputs();
        @(negedge CLK); #1;
        n_checks++;
        if (bus.MEM_ADDR !== 28'd0 || bus.MEM_WRITE_DATA !== 128'd0 || bus.BUSY_WAIT !== 1'b0)
            $display("FAIL idle_outputs got addr=%h bw=%b want 0/0", bus.MEM_ADDR, bus.BUSY_WAIT);
        else n_pass++;
        model_reset();
    endtask

    task automatic test_first_fetch();
        mem_wait = 3;
        mem[28'h4] = 128'h44443333_22221111_800080F0_DEADBEEF;
        coh[28'h4] = mem[28'h4];
        access(4'b1010, 3'b000, 32'h40, 32'd0, rd, b);
        n_checks++;
        if (rd !== 32'hDEADBEEF || b !== 6) $display("FAIL first_fetch got %h/%0d want deadbeef/6", rd, b);
        else n_pass++;
    endtask

    task automatic test_load_types();
        logic [3:0]  re   [4] = '{4'b1000, 4'b1100, 4'b1001, 4'b1101};
        logic [31:0] ad   [4] = '{32'h44, 32'h44, 32'h46, 32'h46};
        logic [31:0] want [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_8000};
        mem_wait = 0;
        for (int i = 0; i < 4; i++) begin
            access(re[i], 3'b000, ad[i], 32'd0, rd, b);
            n_checks++;
            if (rd !== want[i] || b !== 0) $display("FAIL load_type%0d got %h/%0d want %h/0", i, rd, b, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_store_hits();
        access(4'b0000, 3'b100, 32'h41, 32'h0000_00AB, rd, b);
        access(4'b0000, 3'b101, 32'h42, 32'h0000_1234, rd, b);
        access(4'b1010, 3'b000, 32'h40, 32'd0, rd, b);
        n_checks++;
        if (rd !== 32'h1234_ABEF || b !== 0) $display("FAIL store_merge got %h/%0d want 1234abef/0", rd, b);
        else n_pass++;
    endtask

    task automatic test_dirty_evict();
        mem_wait = 0;
        access(4'b1010, 3'b000, 32'hC0, 32'd0, rd, b);
        n_checks++;
        if (b !== 4) $display("FAIL dirty_penalty got %0d want 4", b);
        else n_pass++;
        n_checks++;
        if (mem[28'h4] !== 128'h44443333_22221111_800080F0_1234ABEF)
            $display("FAIL evicted_line got %h want 44443333222211118000 80f01234abef", mem[28'h4]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        int n = 0;
        mem_wait = 0;
        access(4'b1010, 3'b000, 32'h000, 32'd0, rd, b);
        mem_wait = 5;
        touch(28'h14);
        @(negedge CLK);
        bus.READ_EN = 4'b1010; bus.ADDR = 32'h140;
        #1;
        while (bus.MEM_READ !== 1'b1 && n < 20) begin
            n++;
            @(negedge CLK); #1;
        end
        n_checks++;
        if (bus.MEM_READ !== 1'b1) $display("FAIL mid_fetch_reach got %b want 1", bus.MEM_READ);
        else n_pass++;
        RESET = 1'b0;
        @(negedge CLK); #1;
        n_checks++;
        if (bus.MEM_READ !== 1'b0 || bus.BUSY_WAIT !== 1'b0)
            $display("FAIL reset_abort got r=%b bw=%b want 0/0", bus.MEM_READ, bus.BUSY_WAIT);
        else n_pass++;
        RESET = 1'b1;
        #1;
        n_checks++;
        if (bus.BUSY_WAIT !== 1'b1) $display("FAIL remiss_after_reset got %b want 1", bus.BUSY_WAIT);
        else n_pass++;
        idle_inputs();
        model_reset();
        mem_wait = 1;
        access(4'b1010, 3'b000, 32'h000, 32'd0, rd, b);
        access(4'b1010, 3'b000, 32'h140, 32'd0, rd, b);
    endtask

    task automatic test_simultaneous();
        mem_wait = 0;
        access(4'b1010, 3'b110, 32'h144, 32'h5A5A_0F0F, rd, b);
        access(4'b1010, 3'b000, 32'h144, 32'd0, rd, b);
        n_checks++;
        if (rd !== 32'h5A5A_0F0F || b !== 0) $display("FAIL simul_commit got %h/%0d want 5a5a0f0f/0", rd, b);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0]  lfn [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
        logic [31:0] a;
        logic [3:0]  re;
        logic [2:0]  we;
        int          kind;
        for (int i = 0; i < 80; i++) begin
            a = 32'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
            mem_wait = $urandom_range(0, 2);
            kind = $urandom_range(0, 3);
            re = (kind != 2) ? {1'b1, lfn[$urandom_range(0, 5)]} : 4'b0000;
            we = (kind >= 2) ? {1'b1, 2'($urandom_range(0, 2))} : 3'b000;
            access(re, we, a, $urandom, rd, b);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_first_fetch();
        test_load_types();
        test_store_hits();
        test_dirty_evict();
        test_reset_mid_fetch();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
